// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: opcodes, FSM states
// and the bit layout of the 16-bit instruction word.
package alu_seq_pkg;

    localparam int REG_AW = 2;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_NOT = 3'd2;
    localparam logic [OP_W-1:0] OP_AND = 3'd3;
    localparam logic [OP_W-1:0] OP_OR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR = 3'd5;
    localparam logic [OP_W-1:0] OP_SHL = 3'd6;
    localparam logic [OP_W-1:0] OP_SHR = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int OP_HI       = 15;
    localparam int OP_LO       = 13;
    localparam int IMM_SEL_BIT = 12;
    localparam int RD_HI       = 11;
    localparam int RD_LO       = 10;
    localparam int RS1_HI      = 9;
    localparam int RS1_LO      = 8;
    localparam int RS2_HI      = 7;
    localparam int RS2_LO      = 6;
    localparam int IMM_HI      = 7;
    localparam int IMM_LO      = 0;

endpackage

// File: rtl/regfile_4x8.sv
// Small flop-based register file: two operand read ports, one debug read port,
// one synchronous write port, synchronous clear to zero.
module regfile_4x8
    import alu_seq_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int DW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_addr,
    output logic [DW-1:0]     rs1_data,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic [DW-1:0]     rs2_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DW-1:0]     dbg_data,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DW-1:0]     wr_data
);

    logic [DW-1:0] mem [NREGS];

    // NOTE: clearing every entry on reset forces this array into flops; a RAM
    // macro could not be cleared in one cycle, which is fine at 4 entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rs1_data = mem[rs1_addr];
    assign rs2_data = mem[rs2_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback controller in front of the 8-bit ALU: accepts an instruction,
// drives the ALU for one cycle, writes back, and holds the result until taken.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int DW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DW-1:0]     alu_operand1,
    output logic [DW-1:0]     alu_operand2,
    input  logic [DW-1:0]     alu_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DW-1:0]     res_data,
    output logic [REG_AW-1:0] res_rd,
    output logic              res_zero,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DW-1:0]     dbg_data
);

    state_t            state;
    state_t            state_next;
    logic [OP_W-1:0]   op_q;
    logic [REG_AW-1:0] rd_q;
    logic [DW-1:0]     opa_q;
    logic [DW-1:0]     opb_q;
    logic [DW-1:0]     rs1_data;
    logic [DW-1:0]     rs2_data;
    logic              accept;

    regfile_4x8 #(
        .NREGS (NREGS),
        .DW    (DW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (instr[RS1_HI:RS1_LO]),
        .rs1_data (rs1_data),
        .rs2_addr (instr[RS2_HI:RS2_LO]),
        .rs2_data (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_en    (state == EXEC),
        .wr_addr  (rd_q),
        .wr_data  (alu_result)
    );

    // NOTE: every output of this block gets a default before the case, so no
    // state path can leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        res_valid   = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_next = EXEC;
            end
            EXEC: state_next = DONE;
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = instr_ready && instr_valid;

    // NOTE: non-blocking assignments here, so operand capture sees the regfile
    // as it was before this edge's writeback, matching the read-before-write rule.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            res_data <= '0;
            res_rd   <= '0;
            res_zero <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q  <= instr[OP_HI:OP_LO];
                rd_q  <= instr[RD_HI:RD_LO];
                opa_q <= rs1_data;
                opb_q <= instr[IMM_SEL_BIT] ? instr[IMM_HI:IMM_LO] : rs2_data;
            end
            if (state == EXEC) begin
                res_data <= alu_result;
                res_rd   <= rd_q;
                res_zero <= (alu_result == '0);
            end
        end
    end

    assign alu_opcode   = op_q;
    assign alu_operand1 = opa_q;
    assign alu_operand2 = opb_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer; the bench also plays the ALU
// and tracks the register file with a transaction-level model.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_operand1;
    logic [7:0]  alu_operand2;
    logic [7:0]  alu_result;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_data;
    logic [1:0]  res_rd;
    logic        res_zero;
    logic [1:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] model_regs [4];

    typedef struct {
        logic [7:0] data;
        logic [1:0] rd;
        logic       zero;
        int         lat;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } obs_t;

    alu_sequencer #(.NREGS(4), .DW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .alu_opcode   (alu_opcode),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_result   (alu_result),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_rd       (res_rd),
        .res_zero     (res_zero),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int x = int'(a);
        int y = int'(b);
        int r;
        case (op)
            OP_ADD:  r = (x + y) % 256;
            OP_SUB:  r = (x - y + 256) % 256;
            OP_NOT:  r = 255 - x;
            OP_AND:  r = int'(a & b);
            OP_OR:   r = int'(a | b);
            OP_XOR:  r = int'(a ^ b);
            OP_SHL:  r = (x * 2) % 256;
            default: r = x / 2;
        endcase
        return 8'(r);
    endfunction

    assign alu_result = ref_alu(alu_opcode, alu_operand1, alu_operand2);

    function automatic logic [15:0] mk_i(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [7:0] imm);
        return {op, 1'b1, rd, rs1, imm};
    endfunction

    function automatic logic [15:0] mk_r(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, 1'b0, rd, rs1, rs2, 6'b0};
    endfunction

    // Applies one instruction to the architectural model; returns result and operands.
    function automatic void model_exec(input logic [15:0] ins, output logic [7:0] res,
                                       output logic [7:0] a, output logic [7:0] b);
        logic [2:0] op = ins[15:13];
        logic [1:0] rd = ins[11:10];
        a   = model_regs[ins[9:8]];
        b   = ins[12] ? ins[7:0] : model_regs[ins[7:6]];
        res = ref_alu(op, a, b);
        model_regs[rd] = res;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;
    endfunction

    // Issues one instruction from a negedge, records what the DUT shows, retires it.
    task automatic send(input logic [15:0] ins, input int stall, output obs_t o);
        int n = 0;
        instr = ins;
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        instr_valid = 1'b0;
        o.op = alu_opcode;
        o.a = alu_operand1;
        o.b = alu_operand2;
        o.lat = 1;
        while (!res_valid && o.lat < 20) begin
            @(negedge clk);
            o.lat++;
        end
        o.data = res_data;
        o.rd = res_rd;
        o.zero = res_zero;
        repeat (stall) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL reset instr_ready: got %b want 1", instr_ready); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset res_valid: got %b want 0", res_valid); end
        vectors++; if ({res_data, res_rd, res_zero} !== 11'h0) begin miscompares++; $display("FAIL reset res regs: got %h/%h/%b want 0", res_data, res_rd, res_zero); end
        vectors++; if ({alu_opcode, alu_operand1, alu_operand2} !== 19'h0) begin miscompares++; $display("FAIL reset alu outs: got %h/%h/%h want 0", alu_opcode, alu_operand1, alu_operand2); end
        for (int k = 0; k < 4; k++) begin
            dbg_addr = 2'(k);
            #1;
            vectors++; if (dbg_data !== 8'h00) begin miscompares++; $display("FAIL reset dbg r%0d: got %h want 00", k, dbg_data); end
        end
    endtask

    task automatic test_add_wrap();
        obs_t o;
        logic [7:0] e, a, b;
        logic [15:0] ins;
        ins = mk_i(OP_ADD, 2'd1, 2'd0, 8'h05);
        model_exec(ins, e, a, b);
        send(ins, 0, o);
        vectors++; if (o.data !== 8'h05 || e !== 8'h05) begin miscompares++; $display("FAIL add_imm data: got %h want 05", o.data); end
        vectors++; if (o.rd !== 2'd1) begin miscompares++; $display("FAIL add_imm rd: got %0d want 1", o.rd); end
        vectors++; if (o.lat !== 2) begin miscompares++; $display("FAIL add_imm latency: got %0d want 2", o.lat); end
        vectors++; if (o.zero !== 1'b0) begin miscompares++; $display("FAIL add_imm zero: got %b want 0", o.zero); end
        ins = mk_i(OP_ADD, 2'd1, 2'd1, 8'hFB);
        model_exec(ins, e, a, b);
        send(ins, 0, o);
        vectors++; if (o.data !== e) begin miscompares++; $display("FAIL add_wrap data: got %h want %h", o.data, e); end
        vectors++; if (o.zero !== 1'b1) begin miscompares++; $display("FAIL add_wrap zero: got %b want 1", o.zero); end
        vectors++; if (o.a !== a || o.b !== b) begin miscompares++; $display("FAIL add_wrap operands: got %h/%h want %h/%h", o.a, o.b, a, b); end
    endtask

    task automatic test_sub_shift();
        obs_t o;
        logic [7:0] e, a, b;
        logic [15:0] ins;
        ins = mk_i(OP_ADD, 2'd1, 2'd0, 8'h01);
        model_exec(ins, e, a, b);
        send(ins, 0, o);
        vectors++; if (o.data !== e) begin miscompares++; $display("FAIL set_r1 data: got %h want %h", o.data, e); end
        ins = mk_r(OP_SUB, 2'd3, 2'd2, 2'd1);
        model_exec(ins, e, a, b);
        send(ins, 0, o);
        vectors++; if (o.data !== 8'hFF || e !== 8'hFF) begin miscompares++; $display("FAIL sub_reg data: got %h want ff", o.data); end
        vectors++; if (o.op !== OP_SUB || o.a !== a || o.b !== b) begin miscompares++; $display("FAIL sub_reg alu inputs: got %h/%h/%h want %h/%h/%h", o.op, o.a, o.b, OP_SUB, a, b); end
        dbg_addr = 2'd3;
        #1;
        vectors++; if (dbg_data !== model_regs[3]) begin miscompares++; $display("FAIL sub_reg writeback r3: got %h want %h", dbg_data, model_regs[3]); end
        ins = mk_i(OP_SHR, 2'd2, 2'd3, 8'h00);
        model_exec(ins, e, a, b);
        send(ins, 0, o);
        vectors++; if (o.data !== 8'h7F || e !== 8'h7F) begin miscompares++; $display("FAIL shr1 data: got %h want 7f", o.data); end
        ins = mk_i(OP_SHL, 2'd2, 2'd3, 8'h00);
        model_exec(ins, e, a, b);
        send(ins, 0, o);
        vectors++; if (o.data !== 8'hFE || e !== 8'hFE) begin miscompares++; $display("FAIL shl1 data: got %h want fe", o.data); end
    endtask

    task automatic test_backpressure();
        logic [7:0] e1, a1, b1, e2, a2, b2;
        logic [15:0] ins1, ins2;
        int n = 0;
        ins1 = mk_i(OP_OR, 2'd1, 2'd1, 8'h3C);
        ins2 = mk_i(OP_ADD, 2'd0, 2'd1, 8'h01);
        model_exec(ins1, e1, a1, b1);
        instr = ins1;
        instr_valid = 1'b1;
        @(negedge clk);
        instr = ins2;
        while (!res_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        vectors++; if (n !== 1) begin miscompares++; $display("FAIL bp latency: got %0d want 1", n); end
        for (int i = 0; i < 5; i++) begin
            vectors++; if (res_valid !== 1'b1 || res_data !== e1 || res_rd !== 2'd1 || instr_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp hold cycle %0d: got v=%b d=%h rd=%0d rdy=%b want v=1 d=%h rd=1 rdy=0", i, res_valid, res_data, res_rd, instr_ready, e1);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        vectors++; if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin miscompares++; $display("FAIL bp release: got v=%b rdy=%b want v=0 rdy=1", res_valid, instr_ready); end
        @(negedge clk);
        instr_valid = 1'b0;
        model_exec(ins2, e2, a2, b2);
        vectors++; if (alu_opcode !== OP_ADD || alu_operand1 !== a2 || alu_operand2 !== b2) begin
            miscompares++;
            $display("FAIL bp pending alu inputs: got %h/%h/%h want %h/%h/%h", alu_opcode, alu_operand1, alu_operand2, OP_ADD, a2, b2);
        end
        @(negedge clk);
        vectors++; if (res_valid !== 1'b1 || res_data !== e2 || res_rd !== 2'd0) begin miscompares++; $display("FAIL bp pending result: got v=%b d=%h rd=%0d want 1/%h/0", res_valid, res_data, res_rd, e2); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_dependent_chain();
        obs_t o;
        logic [7:0] e, a, b;
        logic [15:0] ins;
        ins = mk_i(OP_AND, 2'd1, 2'd1, 8'h00);
        model_exec(ins, e, a, b);
        send(ins, 0, o);
        vectors++; if (o.data !== 8'h00) begin miscompares++; $display("FAIL chain clear r1: got %h want 00", o.data); end
        ins = mk_i(OP_XOR, 2'd1, 2'd1, 8'hAA);
        model_exec(ins, e, a, b);
        send(ins, 0, o);
        vectors++; if (o.data !== e) begin miscompares++; $display("FAIL chain xor: got %h want %h", o.data, e); end
        ins = mk_r(OP_AND, 2'd2, 2'd1, 2'd1);
        model_exec(ins, e, a, b);
        send(ins, 1, o);
        vectors++; if (o.data !== 8'hAA || e !== 8'hAA) begin miscompares++; $display("FAIL chain and raw: got %h want aa", o.data); end
        dbg_addr = 2'd2;
        #1;
        vectors++; if (dbg_data !== model_regs[2]) begin miscompares++; $display("FAIL chain r2 writeback: got %h want %h", dbg_data, model_regs[2]); end
    endtask

    task automatic test_reset_in_exec();
        instr = mk_i(OP_ADD, 2'd2, 2'd0, 8'h33);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        dbg_addr = 2'd2;
        #1;
        vectors++; if (dbg_data !== 8'h00) begin miscompares++; $display("FAIL rst_exec r2: got %h want 00", dbg_data); end
        vectors++; if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin miscompares++; $display("FAIL rst_exec state: got v=%b rdy=%b want 0/1", res_valid, instr_ready); end
        @(negedge clk);
        vectors++; if (res_valid !== 1'b0 || instr_ready !== 1'b1 || dbg_data !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_exec settle: got v=%b rdy=%b r2=%h want 0/1/00", res_valid, instr_ready, dbg_data);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [7:0] e, a, b;
        logic [15:0] ins;
        for (int t = 0; t < 40; t++) begin
            ins = 16'($urandom);
            model_exec(ins, e, a, b);
            send(ins, int'($urandom_range(0, 2)), o);
            vectors++; if (o.data !== e || o.rd !== ins[11:10] || o.zero !== (e == 8'h00)) begin
                miscompares++;
                $display("FAIL rand %0d ins=%h result: got %h/%0d/%b want %h/%0d/%b", t, ins, o.data, o.rd, o.zero, e, ins[11:10], (e == 8'h00));
            end
            vectors++; if (o.op !== ins[15:13] || o.a !== a || o.b !== b || o.lat !== 2) begin
                miscompares++;
                $display("FAIL rand %0d ins=%h issue: got %h/%h/%h lat %0d want %h/%h/%h lat 2", t, ins, o.op, o.a, o.b, o.lat, ins[15:13], a, b);
            end
        end
        for (int k = 0; k < 4; k++) begin
            dbg_addr = 2'(k);
            #1;
            vectors++; if (dbg_data !== model_regs[k]) begin miscompares++; $display("FAIL rand final r%0d: got %h want %h", k, dbg_data, model_regs[k]); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_wrap();
        test_sub_shift();
        test_backpressure();
        test_dependent_chain();
        test_reset_in_exec();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
